// File: rtl/chunked_serial_comparator_if.sv
// Handshake and result bundle for chunked_serial_comparator.
// The master drives start/cascade/chunk inputs, and the slave (the comparator) returns status and flags.
interface chunked_serial_comparator_if #(
    parameter int N = 4
);
    logic         start;
    logic         i_gt;
    logic         i_eq;
    logic         i_lt;
    logic [N-1:0] a_chunk;
    logic [N-1:0] b_chunk;
    logic         chunk_valid;
    logic         chunk_ready;
    logic         busy;
    logic         result_valid;
    logic         o_gt;
    logic         o_eq;
    logic         o_lt;

    modport master (
        output start, i_gt, i_eq, i_lt, a_chunk, b_chunk, chunk_valid,
        input  chunk_ready, busy, result_valid, o_gt, o_eq, o_lt
    );

    modport slave (
        input  start, i_gt, i_eq, i_lt, a_chunk, b_chunk, chunk_valid,
        output chunk_ready, busy, result_valid, o_gt, o_eq, o_lt
    );
endinterface

// File: rtl/chunked_serial_comparator.sv
// Serial unsigned magnitude comparator: compares N*CHUNKS-bit operands one N-bit chunk per transfer, MSB chunk first.
// Optional CMP_EARLY_EXIT_EN: finish on the first transfer that leaves the comparison decided.
module chunked_serial_comparator #(
    parameter int N      = 4,
    parameter int CHUNKS = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    chunked_serial_comparator_if.slave bus
);
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {CMP_EQ = 2'd0, CMP_GT = 2'd1, CMP_LT = 2'd2} cmp_t;

    state_t         state, state_nx;
    cmp_t           cmp, cmp_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [2:0]     res_flags;
    logic           load_res;

    // Cascade priority: gt over lt over eq; nothing asserted also means equal so far.
    function automatic cmp_t cascade_load(input logic gt, input logic eq, input logic lt);
        if (gt)      return CMP_GT;
        else if (lt) return CMP_LT;
        else if (eq) return CMP_EQ;
        else         return CMP_EQ;
    endfunction

    function automatic cmp_t chunk_cmp(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a > b)      return CMP_GT;
        else if (a < b) return CMP_LT;
        else            return CMP_EQ;
    endfunction

    always_comb begin
        state_nx = state;
        cmp_nx   = cmp;
        cnt_nx   = cnt;
        load_res = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    cmp_nx   = cascade_load(bus.i_gt, bus.i_eq, bus.i_lt);
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.chunk_valid) begin
                    cnt_nx = cnt + 1'b1;
                    // GT/LT are sticky: only an undecided state looks at the chunk.
                    if (cmp == CMP_EQ)
                        cmp_nx = chunk_cmp(bus.a_chunk, bus.b_chunk);
`ifdef CMP_EARLY_EXIT_EN
                    if (cnt == LAST || cmp_nx != CMP_EQ) begin
`else
                    if (cnt == LAST) begin
`endif
                        load_res = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Register stage: FSM, running comparison and held result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmp       <= CMP_EQ;
            cnt       <= '0;
            res_flags <= 3'b000;
        end else begin
            state <= state_nx;
            cmp   <= cmp_nx;
            cnt   <= cnt_nx;
            if (load_res)
                res_flags <= {cmp_nx == CMP_GT, cmp_nx == CMP_EQ, cmp_nx == CMP_LT};
        end
    end

    assign bus.chunk_ready  = (state == RUN);
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.o_gt         = res_flags[2];
    assign bus.o_eq         = res_flags[1];
    assign bus.o_lt         = res_flags[0];
endmodule

// File: tb/tb_chunked_serial_comparator.sv
// Scoreboard bench for chunked_serial_comparator: a driver pushes whole-operand expectations, and a monitor checks each result pulse.
module tb_chunked_serial_comparator;
    localparam int N      = 4;
    localparam int CHUNKS = 4;
    localparam int W      = N * CHUNKS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chunked_serial_comparator_if #(.N(N)) bus ();

    chunked_serial_comparator #(.N(N), .CHUNKS(CHUNKS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0] flags;
        int         xfers;
    } exp_t;

    exp_t       sb[$];
    int         checks    = 0;
    int         failures  = 0;
    logic [2:0] last_exp  = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Whole-operand reference: cascade decides first, otherwise plain unsigned compare.
    function automatic logic [2:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cg, input logic cl);
        if (cg)    return 3'b100;
        if (cl)    return 3'b001;
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int model_xfers(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cg, input logic cl);
        int   n     = CHUNKS;
        logic early = 1'b0;
`ifdef CMP_EARLY_EXIT_EN
        early = 1'b1;
`endif
        if (early) begin
            if (cg || cl) n = 1;
            else if (a != b) begin
                for (int p = 0; p < W; p++)
                    if (a[p] != b[p]) n = CHUNKS - p / N;
            end
        end
        return n;
    endfunction

    // Monitor: counts accepted chunks and scores each result pulse.
    initial begin
        int   xcnt     = 0;
        logic prev_acc = 1'b0;
        logic acc;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                xcnt     = 0;
                prev_acc = 1'b0;
            end else begin
                if (bus.result_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("flags", {29'd0, bus.o_gt, bus.o_eq, bus.o_lt}, {29'd0, e.flags});
                        check("xfers", xcnt, e.xfers);
                        check("latency", {31'd0, prev_acc}, 32'd1);
                        check("ready_in_done", {31'd0, bus.chunk_ready}, 32'd0);
                    end
                    xcnt = 0;
                end
                acc = bus.chunk_valid && bus.chunk_ready;
                if (acc) xcnt++;
                prev_acc = acc;
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {26'd0, bus.chunk_ready, bus.busy, bus.result_valid,
                                bus.o_gt, bus.o_eq, bus.o_lt}, 32'd0);
        bus.start       = 1'b0;
        bus.chunk_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    // stall: 0 = valid every cycle, 1 = random, 2 = toggle 1/0. abort_after >= 0 resets after that many transfers.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cg, input logic ce, input logic cl,
                         input int stall, input int abort_after, input bit hold_start);
        int   idx = CHUNKS - 1;
        int   xf  = 0;
        int   g   = 0;
        logic acc;
        wait_idle();
        bus.start = 1'b1;
        bus.i_gt  = cg;
        bus.i_eq  = ce;
        bus.i_lt  = cl;
        if (abort_after < 0) begin
            sb.push_back('{model_flags(a, b, cg, cl), model_xfers(a, b, cg, cl)});
            last_exp = model_flags(a, b, cg, cl);
        end
        @(posedge clk); #1;
        if (!hold_start) bus.start = 1'b0;
        bus.i_gt = 1'($urandom);
        bus.i_eq = 1'($urandom);
        bus.i_lt = 1'($urandom);
        while (idx >= 0 && g < 400) begin
            if (abort_after >= 0 && xf == abort_after) begin
                apply_reset();
                return;
            end
            bus.a_chunk = a[idx*N +: N];
            bus.b_chunk = b[idx*N +: N];
            case (stall)
                0:       bus.chunk_valid = 1'b1;
                1:       bus.chunk_valid = 1'($urandom_range(0, 1));
                default: bus.chunk_valid = (g % 2 == 0);
            endcase
            acc = bus.chunk_valid && bus.chunk_ready;
            @(posedge clk); #1;
            g++;
            if (acc) begin
                idx--;
                xf++;
            end
            if (!bus.chunk_ready && xf > 0) break;
        end
        bus.chunk_valid = 1'b0;
        bus.a_chunk     = N'($urandom);
        bus.b_chunk     = N'($urandom);
        check("feed_timeout", {31'd0, g >= 400}, 32'd0);
        if (hold_start) begin
            @(posedge clk); #1;
            check("start_ignored_in_done", {31'd0, bus.busy}, 32'd0);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           r, k;
        bus.start       = 1'b0;
        bus.i_gt        = 1'b0;
        bus.i_eq        = 1'b0;
        bus.i_lt        = 1'b0;
        bus.a_chunk     = '0;
        bus.b_chunk     = '0;
        bus.chunk_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {26'd0, bus.chunk_ready, bus.busy, bus.result_valid,
                              bus.o_gt, bus.o_eq, bus.o_lt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {30'd0, bus.chunk_ready, bus.busy}, 32'd0);

        do_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0);
        do_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);
        do_op(16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);
        do_op(16'h1230, 16'h1231, 1'b0, 1'b1, 1'b0, 2, -1, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 0, -1, 1'b0);
        do_op(16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
        do_op(16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0);
        do_op(16'h4321, 16'h4322, 1'b0, 1'b1, 1'b0, 0, -1, 1'b1);
        do_op(16'hA000, 16'h5000, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            r = $urandom_range(0, 2);
            k = $urandom_range(0, CHUNKS - 1);
            b = a;
            if (r == 1) b[k*N +: N] = N'($urandom);
            else if (r == 2) b = W'($urandom);
            r = $urandom_range(0, 7);
            do_op(a, b, r == 0 || r == 2, r > 3, r == 1 || r == 2,
                  $urandom_range(0, 1), -1, (i % 10) == 3);
        end

        do_op(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0);
        do_op(16'hC3C3, 16'hC3C2, 1'b0, 1'b1, 1'b0, 1, -1, 1'b0);

        begin
            int g = 0;
            while (sb.size() != 0 && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
        end
        check("drain", sb.size(), 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("hold", {29'd0, bus.o_gt, bus.o_eq, bus.o_lt}, {29'd0, last_exp});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
